multicycle_adder: RTL and testbench
===================================

MULTICYCLE_ADDER -- requirements
Module: multicycle_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits.
REQ-002 Parameter CHUNK, default 8, number of bits added per clock cycle.
REQ-003 Derived constant NCHUNK = WIDTH/CHUNK, the number of processing cycles per operation.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  request a new operation; sampled only in IDLE or DONE.
REQ-008 a  input  WIDTH  operand A; captured on the edge that accepts start.
REQ-009 b  input  WIDTH  operand B; captured on the edge that accepts start.
REQ-010 cin  input  1  carry-in; captured on the edge that accepts start.
REQ-011 sub  input  1  mode: 0 computes a+b+cin, 1 computes a-b-cin; captured on the edge that accepts start.
REQ-012 busy  output  1  high while an operation is in progress.
REQ-013 done  output  1  single-cycle pulse; result is valid and updated.
REQ-014 sum  output  WIDTH  registered result.
REQ-015 cout  output  1  carry out of the MSB; in sub mode 1 means no borrow.
REQ-016 ovf  output  1  signed two's-complement overflow flag.

Function
REQ-017 Elaboration SHALL fail if CHUNK<1, CHUNK>WIDTH, or WIDTH mod CHUNK != 0.
REQ-018 FSM states: IDLE, BUSY, DONE. Transitions:
- IDLE -> BUSY on start.
- BUSY -> DONE after NCHUNK BUSY edges.
- DONE -> BUSY on start, otherwise DONE -> IDLE.
REQ-019 Accept edge: a, b, cin and sub are latched, the chunk counter is cleared to 0, and the internal carry is set.
- sub=0: carry = cin and the B copy is stored as b.
- sub=1: carry = ~cin and the B copy is stored as ~b.
REQ-020 Each BUSY edge processes one chunk, LSB chunk first:
- chunk i of the internal result = A[i] + B[i] + carry, taking the low CHUNK bits.
- carry becomes the carry out of that chunk.
- the counter increments.
REQ-021 On the edge that processes the last chunk (counter = NCHUNK-1), the block SHALL:
- load sum with the full internal result;
- load cout with the final carry;
- load ovf with (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1);
- enter DONE.
REQ-022 sum, cout and ovf SHALL hold their values between DONE pulses and SHALL NOT change while BUSY.
REQ-023 Latency: if start is accepted on edge k, done is high in the cycle following edge k+NCHUNK.
- With CHUNK=WIDTH, done is high in the cycle following edge k+1.
REQ-024 busy SHALL be 1 exactly in the BUSY state; done SHALL be 1 exactly in the DONE state.
REQ-025 start SHALL be ignored in the BUSY state; operands are not re-latched and the in-flight result is unaffected.
REQ-026 start in the DONE state SHALL be accepted, giving back-to-back operation with no IDLE cycle; done deasserts on the next edge.
REQ-027 Input changes on a, b, cin and sub after the accept edge SHALL NOT affect the in-flight result.
REQ-028 Arithmetic wraps modulo 2^WIDTH; the carry is reported only via cout.

Reset
REQ-029 When rst_n is low, the block SHALL immediately force:
- state = IDLE, counter = 0, internal carry = 0;
- busy = 0, done = 0, sum = 0, cout = 0, ovf = 0.
REQ-030 Reset during BUSY SHALL abort the operation with no done pulse and no result update.
REQ-031 The first rising clk edge with rst_n high SHALL accept start if start is asserted.

Verification (WIDTH=8, CHUNK=4, NCHUNK=2)
REQ-032 a=0xFF, b=0x01, cin=0, sub=0, start on edge k -> busy high after edges k and k+1; done high after edge k+2; sum=0x00, cout=1, ovf=0.
REQ-033 a=0x7F, b=0x01, cin=0, sub=0 -> sum=0x80, cout=0, ovf=1.
REQ-034 a=0x05, b=0x07, cin=0, sub=1 -> sum=0xFE, cout=0, ovf=0; then a=0x80, b=0x01, cin=0, sub=1 -> sum=0x7F, cout=1, ovf=1.
REQ-035 Start with a=0x10, b=0x20, then start again in the BUSY cycle with a=0xAA, b=0x55 -> second start ignored, single done, sum=0x30.
REQ-036 Start held high in the DONE cycle with a=0x01, b=0x02, cin=1 -> first done pulse, then a second done 2 edges later with sum=0x04; no IDLE cycle between the operations.
REQ-037 Previous sum=0x30; rst_n pulsed low while BUSY -> busy, done, sum, cout and ovf are immediately 0; no done pulse; the next start completes normally.

Source files
------------

// File: rtl/multicycle_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock, LSB chunk first,
// and reports sum, carry-out and signed overflow with a single-cycle done pulse.
module multicycle_adder #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NCHUNK = (CHUNK > 0) ? WIDTH / CHUNK : 1;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

   generate
      if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
         $error("multicycle_adder: CHUNK must be in 1..WIDTH and divide WIDTH");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q;
   logic             carry_q;
   logic [WIDTH-1:0] a_q, b_q, res_q;

   logic             accept, last;
   int               lsb;
   logic [CHUNK:0]   csum;
   logic [WIDTH-1:0] res_d;
   logic             ovf_d;

   assign accept = start && (state_q == IDLE || state_q == DONE);
   assign last   = (state_q == BUSY) && (cnt_q == LAST);
   assign busy   = (state_q == BUSY);
   assign done   = (state_q == DONE);

   // NOTE: every signal driven in an always_comb gets a default first, so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = BUSY;
         BUSY:    if (cnt_q == LAST) state_d = DONE;
         DONE:    state_d = start ? BUSY : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // One chunk of the ripple: the current chunk slice plus the running carry.
   always_comb begin
      lsb   = int'(cnt_q) * CHUNK;
      csum  = {1'b0, a_q[lsb +: CHUNK]} + {1'b0, b_q[lsb +: CHUNK]}
            + {{CHUNK{1'b0}}, carry_q};
      res_d = res_q;
      res_d[lsb +: CHUNK] = csum[CHUNK-1:0];
      // a^b^s at the MSB recovers the carry into it; xor with carry out is overflow.
      ovf_d = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ res_d[WIDTH-1] ^ csum[CHUNK];
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         sum     <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            cnt_q   <= '0;
            carry_q <= cin ^ sub;
         end else if (state_q == BUSY) begin
            cnt_q   <= cnt_q + CW'(1);
            carry_q <= csum[CHUNK];
         end
         if (last) begin
            sum  <= res_d;
            cout <= csum[CHUNK];
            ovf  <= ovf_d;
         end
      end
   end

   // NOTE: operand and partial-result registers are deliberately not reset;
   // they are always written on accept or during BUSY before being observed.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_q <= a;
         b_q <= sub ? ~b : b;
      end else if (state_q == BUSY) begin
         res_q <= res_d;
      end
   end

endmodule

// File: tb/tb_multicycle_adder.sv
// Directed self-checking bench for multicycle_adder (WIDTH=8, CHUNK=4).
module tb_multicycle_adder;

   localparam int WIDTH = 8;
   localparam int CHUNK = 4;

   logic             clk, rst_n, start, cin, sub;
   logic [WIDTH-1:0] a, b;
   logic             busy, done, cout, ovf;
   logic [WIDTH-1:0] sum;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic       sub;
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
   } vec_t;

   vec_t vecs[9];

   multicycle_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .sub   (sub),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Starts one operation and checks exact latency, result, and that operand
   // changes after the accept edge do not disturb it.
   task automatic run_op(input vec_t v, input string tag);
      @(negedge clk);
      check({tag, " idle done"}, done, 0);
      a = v.a; b = v.b; cin = v.cin; sub = v.sub; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, " busy1"}, busy, 1);
      check({tag, " done1"}, done, 0);
      a = ~v.a; b = ~v.b; cin = ~v.cin; sub = ~v.sub;
      @(negedge clk);
      check({tag, " busy2"}, busy, 1);
      @(negedge clk);
      check({tag, " done"}, done, 1);
      check({tag, " busy3"}, busy, 0);
      check({tag, " sum"}, sum, v.sum);
      check({tag, " cout"}, cout, v.cout);
      check({tag, " ovf"}, ovf, v.ovf);
   endtask

   initial begin
      //          a      b      cin   sub   sum    cout  ovf
      vecs[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
      vecs[2] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
      vecs[3] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
      vecs[4] = '{8'h0F, 8'h01, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0};
      vecs[5] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
      vecs[6] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
      vecs[7] = '{8'h3C, 8'h4A, 1'b0, 1'b0, 8'h86, 1'b0, 1'b1};
      vecs[8] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};

      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      #12;
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset sum", sum, 0);
      check("reset cout", cout, 0);
      check("reset ovf", ovf, 0);

      // Start already high when reset releases: first edge accepts it.
      a = 8'h01; b = 8'h01; start = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("first edge busy", busy, 1);
      @(negedge clk);
      check("first edge busy2", busy, 1);
      @(negedge clk);
      check("first edge done", done, 1);
      check("first edge sum", sum, 8'h02);

      foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

      // Start during BUSY is ignored; single done with the original result.
      @(negedge clk);
      a = 8'h10; b = 8'h20; cin = 1'b0; sub = 1'b0; start = 1'b1;
      @(negedge clk);
      a = 8'hAA; b = 8'h55;
      @(negedge clk);
      start = 1'b0;
      check("busy start ignored busy", busy, 1);
      check("busy start ignored done", done, 0);
      @(negedge clk);
      check("busy start done", done, 1);
      check("busy start sum", sum, 8'h30);
      @(negedge clk);
      check("busy start single done", done, 0);
      check("busy start idle", busy, 0);

      // Back-to-back: start held in the DONE cycle skips IDLE.
      run_op('{8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0}, "b2b first");
      a = 8'h01; b = 8'h02; cin = 1'b1; sub = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("b2b no idle busy", busy, 1);
      check("b2b done dropped", done, 0);
      check("b2b sum held", sum, 8'h07);
      @(negedge clk);
      check("b2b busy2", busy, 1);
      @(negedge clk);
      check("b2b done", done, 1);
      check("b2b sum", sum, 8'h04);

      // Reset while BUSY aborts immediately with no done pulse.
      run_op('{8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0}, "pre-reset");
      @(negedge clk);
      a = 8'h11; b = 8'h22; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("abort busy before", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("abort busy", busy, 0);
      check("abort done", done, 0);
      check("abort sum", sum, 0);
      check("abort cout", cout, 0);
      check("abort ovf", ovf, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("abort no done %0d", i), done, 0);
      end
      run_op('{8'h22, 8'h33, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0}, "after reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
